regfile_wb_arbiter: RTL

Write-back front end for the 64-bit register bank. Two result producers hand in (rd, data) pairs over valid/ready channels: channel A is the ALU, channel B is the load unit. Each channel has its own small FIFO, and a round-robin arbiter merges them onto the bank's single registered write port (wr_en/ptr_wr/data_wr). The block also publishes a per-register pending vector for hazard detection in issue logic.

---
 rtl/regfile_wb_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back front end: two result channels (A = ALU, B = load), each with its own FIFO,
// merged round-robin onto the single registered write port. Optional counters under WB_STATS_EN.
module regfile_wb_arbiter #(
    parameter int N     = 32,
    parameter int Bits  = 64,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [$clog2(N)-1:0] a_rd,
    input  logic [Bits-1:0]      a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [$clog2(N)-1:0] b_rd,
    input  logic [Bits-1:0]      b_data,
    output logic                 wr_en,
    output logic [$clog2(N)-1:0] ptr_wr,
    output logic [Bits-1:0]      data_wr,
    output logic [N-1:0]         pending
`ifdef WB_STATS_EN
    ,
    output logic [31:0]          wb_count,
    output logic [15:0]          x0_drops
`endif
);
    localparam int RW = $clog2(N);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CH = 2;

    typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

    // Handshake: a pair transfers at a rising edge where valid && ready; ready depends only
    // on FIFO state, and a producer seeing valid && !ready must hold rd/data until accepted.
    logic            in_valid [CH];
    logic [RW-1:0]   in_rd    [CH];
    logic [Bits-1:0] in_data  [CH];

    logic [RW-1:0]    mem_rd    [CH][DEPTH];
    logic [Bits-1:0]  mem_data  [CH][DEPTH];
    logic [PW-1:0]    wp        [CH];
    logic [PW-1:0]    rp        [CH];
    logic             full      [CH];
    logic             empty     [CH];
    logic             push      [CH];
    logic             pop       [CH];
    logic [DEPTH-1:0] ent_valid [CH];

    grant_e          last_grant;
    grant_e          grant_ch;
    logic            grant_any;
    logic            gsel;
    logic [RW-1:0]   head_rd;
    logic [Bits-1:0] head_data;

    assign in_valid[0] = a_valid;
    assign in_rd[0]    = a_rd;
    assign in_data[0]  = a_data;
    assign in_valid[1] = b_valid;
    assign in_rd[1]    = b_rd;
    assign in_data[1]  = b_data;

    assign a_ready = !full[0];
    assign b_ready = !full[1];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            full[c]  = (wp[c][IW-1:0] == rp[c][IW-1:0]) && (wp[c][IW] != rp[c][IW]);
            empty[c] = (wp[c] == rp[c]);
            push[c]  = in_valid[c] && !full[c];
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid[c][i] = ({1'b0, IW'(i) - rp[c][IW-1:0]} < (wp[c] - rp[c]));
            end
        end
    end

    always_comb begin
        grant_any = !empty[0] || !empty[1];
        grant_ch  = GRANT_A;
        if (!empty[0] && !empty[1]) begin
            grant_ch = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
        end else if (!empty[1]) begin
            grant_ch = GRANT_B;
        end
        gsel      = (grant_ch == GRANT_B);
        pop[0]    = grant_any && !gsel;
        pop[1]    = grant_any && gsel;
        head_rd   = mem_rd[gsel][rp[gsel][IW-1:0]];
        head_data = mem_data[gsel][rp[gsel][IW-1:0]];
    end

    // FIFO storage is left unreset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                wp[c] <= '0;
                rp[c] <= '0;
            end
            wr_en      <= 1'b0;
            ptr_wr     <= '0;
            data_wr    <= '0;
            last_grant <= GRANT_A;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (push[c]) begin
                    mem_rd[c][wp[c][IW-1:0]]   <= in_rd[c];
                    mem_data[c][wp[c][IW-1:0]] <= in_data[c];
                    wp[c]                      <= wp[c] + 1'b1;
                end
                if (pop[c]) begin
                    rp[c] <= rp[c] + 1'b1;
                end
            end
            wr_en <= 1'b0;
            if (grant_any) begin
                last_grant <= grant_ch;
                // Writes to x0 are consumed here so the bank never sees them.
                if (head_rd != '0) begin
                    wr_en   <= 1'b1;
                    ptr_wr  <= head_rd;
                    data_wr <= head_data;
                end
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[c][i]) begin
                    pending[mem_rd[c][i]] = 1'b1;
                end
            end
        end
        if (wr_en) begin
            pending[ptr_wr] = 1'b1;
        end
        pending[0] = 1'b0;
    end

`ifdef WB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_count <= '0;
            x0_drops <= '0;
        end else begin
            if (wr_en) begin
                wb_count <= wb_count + 32'd1;
            end
            if (grant_any && (head_rd == '0)) begin
                x0_drops <= x0_drops + 16'd1;
            end
        end
    end
`endif

endmodule
